// File: rtl/codec_arb_pkg.sv
// Shared types and constants for the codec register-port arbiter.
package codec_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        DONE    = 3'd4
    } arb_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } arb_op_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1_000_000;

    // Read data returned to the requester when a read transaction times out.
    localparam logic [7:0] TIMEOUT_RD_DATA = 8'hFF;

endpackage

// File: rtl/rr_grant_sel.sv
// Combinational round-robin pick: the first set request after last_ptr,
// wrapping around so that last_ptr itself has the lowest priority.
module rr_grant_sel #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_ptr,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic             hi_found;
    logic             lo_found;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Scan downwards so the lowest index in each half wins. The "hi" half
    // (above last_ptr) is searched before wrapping to the "lo" half.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int c = NUM_REQ - 1; c >= 0; c--) begin
            if (req[c]) begin
                if (IDX_W'(c) > last_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(c);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = IDX_W'(c);
                end
            end
        end
        grant_valid = hi_found | lo_found;
        grant_idx   = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/codec_reg_arbiter.sv
// Round-robin arbiter sharing one codec register port among NUM_REQ requesters.
// Optional per-transaction timeout is enabled with `define CODEC_ARB_TIMEOUT_EN.
module codec_reg_arbiter
    import codec_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_rd_en,
    input  logic [NUM_REQ-1:0]     req_wr_en,
    input  logic [NUM_REQ*8-1:0]   req_reg_addr,
    input  logic [NUM_REQ*8-1:0]   req_data_in,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic                   req_err,
    output logic [7:0]             req_data_out,
    output logic [NUM_REQ-1:0]     req_data_out_valid,
    output logic                   codec_rd_en,
    output logic                   codec_wr_en,
    output logic [7:0]             codec_reg_addr,
    output logic [7:0]             codec_data_in,
    input  logic [7:0]             codec_data_out,
    input  logic                   codec_data_out_valid,
    input  logic                   controller_busy,
    input  logic                   init_done,
    output logic                   arb_busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("codec_reg_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    // Handshake: a requester holds rd/wr level (and its address/data lane)
    // until req_ack pulses for it; everything is sampled once at grant, so
    // later lane changes or dropped levels do not affect the transaction.

    arb_state_t          state_q, state_d;
    arb_op_t             op_q;
    logic [IDX_W-1:0]    grant_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_valid;
    logic                sel_wr;
    logic [7:0]          sel_addr;
    logic [7:0]          sel_data;
    logic [7:0]          addr_q;
    logic [7:0]          wdata_q;
    logic [7:0]          rdata_q;
    logic                captured_q;
    logic                grant_go;
    logic                in_wait;
    logic [NUM_REQ-1:0]  req_any;
    logic [NUM_REQ-1:0]  grant_onehot;

    assign req_any      = req_rd_en | req_wr_en;
    assign grant_onehot = NUM_REQ'(1) << grant_q;
    assign in_wait      = (state_q == WAIT_HI) || (state_q == WAIT_LO);
    assign grant_go     = (state_q == IDLE) && init_done && !controller_busy && sel_valid;

    rr_grant_sel #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_grant_sel (
        .req         (req_any),
        .last_ptr    (ptr_q),
        .grant_idx   (sel_idx),
        .grant_valid (sel_valid)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_wr   = 1'b0;
        for (int c = 0; c < NUM_REQ; c++) begin
            if (IDX_W'(c) == sel_idx) begin
                sel_addr = req_reg_addr[c*8 +: 8];
                sel_data = req_data_in[c*8 +: 8];
                sel_wr   = req_wr_en[c];
            end
        end
    end

`ifdef CODEC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             timeout_fire;

    // A normal completion on the same cycle as the limit is not a timeout.
    assign timeout_fire = in_wait && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))
                          && !((state_q == WAIT_LO) && !controller_busy);
    assign req_err      = (state_q == DONE) && err_q;
`else
    assign req_err      = 1'b0;
`endif

    always_comb begin
        state_d            = state_q;
        codec_rd_en        = 1'b0;
        codec_wr_en        = 1'b0;
        req_ack            = '0;
        req_data_out_valid = '0;
        case (state_q)
            IDLE: begin
                if (grant_go) state_d = ISSUE;
            end
            ISSUE: begin
                codec_rd_en = (op_q == OP_RD);
                codec_wr_en = (op_q == OP_WR);
                state_d     = WAIT_HI;
            end
            WAIT_HI: begin
                if (controller_busy) state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!controller_busy) state_d = DONE;
            end
            DONE: begin
                req_ack = grant_onehot;
                if (op_q == OP_RD) req_data_out_valid = grant_onehot;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef CODEC_ARB_TIMEOUT_EN
        if (timeout_fire) state_d = DONE;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
            grant_q    <= '0;
            op_q       <= OP_RD;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            captured_q <= 1'b0;
`ifdef CODEC_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (grant_go) begin
                grant_q    <= sel_idx;
                addr_q     <= sel_addr;
                wdata_q    <= sel_data;
                op_q       <= sel_wr ? OP_WR : OP_RD;
                captured_q <= 1'b0;
`ifdef CODEC_ARB_TIMEOUT_EN
                err_q      <= 1'b0;
`endif
            end
            // Only the first valid pulse of a read is kept.
            if (in_wait && (op_q == OP_RD) && !captured_q && codec_data_out_valid) begin
                rdata_q    <= codec_data_out;
                captured_q <= 1'b1;
            end
            if (state_q == DONE) ptr_q <= grant_q;
`ifdef CODEC_ARB_TIMEOUT_EN
            if (state_q == ISSUE) begin
                cnt_q <= '0;
            end else if (in_wait) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (timeout_fire) begin
                err_q <= 1'b1;
                if (op_q == OP_RD) rdata_q <= TIMEOUT_RD_DATA;
            end
`endif
        end
    end

    assign arb_busy       = (state_q != IDLE);
    assign codec_reg_addr = addr_q;
    assign codec_data_in  = wdata_q;
    assign req_data_out   = rdata_q;

endmodule

// File: tb/tb_codec_reg_arbiter.sv
// Directed self-checking bench for codec_reg_arbiter (3 requesters,
// TIMEOUT_CYCLES=50; timeout scenario runs when CODEC_ARB_TIMEOUT_EN is defined).
module tb_codec_reg_arbiter;

    localparam int NUM_REQ = 3;
    localparam int W       = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_REQ-1:0]   req_rd_en;
    logic [NUM_REQ-1:0]   req_wr_en;
    logic [NUM_REQ*8-1:0] req_reg_addr;
    logic [NUM_REQ*8-1:0] req_data_in;
    logic [NUM_REQ-1:0]   req_ack;
    logic                 req_err;
    logic [7:0]           req_data_out;
    logic [NUM_REQ-1:0]   req_data_out_valid;
    logic                 codec_rd_en;
    logic                 codec_wr_en;
    logic [7:0]           codec_reg_addr;
    logic [7:0]           codec_data_in;
    logic [7:0]           codec_data_out;
    logic                 codec_data_out_valid;
    logic                 controller_busy;
    logic                 init_done;
    logic                 arb_busy;

    codec_reg_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .req_rd_en            (req_rd_en),
        .req_wr_en            (req_wr_en),
        .req_reg_addr         (req_reg_addr),
        .req_data_in          (req_data_in),
        .req_ack              (req_ack),
        .req_err              (req_err),
        .req_data_out         (req_data_out),
        .req_data_out_valid   (req_data_out_valid),
        .codec_rd_en          (codec_rd_en),
        .codec_wr_en          (codec_wr_en),
        .codec_reg_addr       (codec_reg_addr),
        .codec_data_in        (codec_data_in),
        .codec_data_out       (codec_data_out),
        .codec_data_out_valid (codec_data_out_valid),
        .controller_busy      (controller_busy),
        .init_done            (init_done),
        .arb_busy             (arb_busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time=%0t required<200000", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];
    logic [1:0]   s_op_q[$];
    logic [7:0]   s_addr_q[$];
    logic [7:0]   s_data_q[$];
    int unsigned  s_cyc_q[$];
    logic [7:0]   a_ack_q[$];
    logic [7:0]   a_vld_q[$];
    logic [7:0]   a_data_q[$];
    logic [7:0]   a_addr_q[$];
    logic [7:0]   a_wdata_q[$];
    logic         a_err_q[$];
    int unsigned  a_cyc_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Strobe and completion monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (codec_rd_en || codec_wr_en) begin
            s_op_q.push_back({codec_wr_en, codec_rd_en});
            s_addr_q.push_back(codec_reg_addr);
            s_data_q.push_back(codec_data_in);
            s_cyc_q.push_back(cyc);
        end
        if (req_ack != '0) begin
            a_ack_q.push_back(8'(req_ack));
            a_vld_q.push_back(8'(req_data_out_valid));
            a_data_q.push_back(req_data_out);
            a_addr_q.push_back(codec_reg_addr);
            a_wdata_q.push_back(codec_data_in);
            a_err_q.push_back(req_err);
            a_cyc_q.push_back(cyc);
        end
    end

    // Codec controller model: busy for busy_len cycles after each strobe;
    // reads return rd_value and then a second, later pulse that must be ignored.
    logic       ctl_enable;
    int         busy_len = 10;
    logic [7:0] rd_value;

    initial begin
        logic is_rd;
        forever begin
            @(negedge clk);
            if (ctl_enable && (codec_rd_en || codec_wr_en)) begin
                is_rd = codec_rd_en;
                @(posedge clk); #1;
                controller_busy = 1'b1;
                for (int i = 0; i < busy_len; i++) begin
                    codec_data_out_valid = 1'b0;
                    if (is_rd && i == 1) begin
                        codec_data_out       = rd_value;
                        codec_data_out_valid = 1'b1;
                    end else if (is_rd && i == 3) begin
                        codec_data_out       = 8'hEE;
                        codec_data_out_valid = 1'b1;
                    end
                    @(posedge clk); #1;
                end
                codec_data_out_valid = 1'b0;
                controller_busy      = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int idx, input logic rd, input logic wr,
                           input logic [7:0] addr, input logic [7:0] data);
        req_rd_en[idx]            = rd;
        req_wr_en[idx]            = wr;
        req_reg_addr[idx*8 +: 8]  = addr;
        req_data_in[idx*8 +: 8]   = data;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Both waits return on the rising edge right after the event was logged.
    task automatic wait_strobes(input int n, input int budget, input string tag);
        int k = 0;
        while (s_op_q.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        check_eq(tag, s_op_q.size(), n);
    endtask

    task automatic wait_acks(input int n, input int budget, input string tag);
        int k = 0;
        while (a_ack_q.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        check_eq(tag, a_ack_q.size(), n);
    endtask

    task automatic clear_logs();
        s_op_q.delete(); s_addr_q.delete(); s_data_q.delete(); s_cyc_q.delete();
        a_ack_q.delete(); a_vld_q.delete(); a_data_q.delete(); a_addr_q.delete();
        a_wdata_q.delete(); a_err_q.delete(); a_cyc_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] exp_addr[6];
        logic [7:0] got_ack;

        exp_addr = '{8'h20, 8'h21, 8'h22, 8'h20, 8'h21, 8'h22};
        reset = 1'b1;
        req_rd_en = '0; req_wr_en = '0; req_reg_addr = '0; req_data_in = '0;
        codec_data_out = '0; codec_data_out_valid = 1'b0; controller_busy = 1'b0;
        init_done = 1'b0; ctl_enable = 1'b1; rd_value = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check_eq("rst_arb_busy",    arb_busy, 0);
        check_eq("rst_req_ack",     req_ack, 0);
        check_eq("rst_req_err",     req_err, 0);
        check_eq("rst_rd_data",     req_data_out, 0);
        check_eq("rst_rd_valid",    req_data_out_valid, 0);
        check_eq("rst_codec_rd",    codec_rd_en, 0);
        check_eq("rst_codec_wr",    codec_wr_en, 0);
        check_eq("rst_codec_addr",  codec_reg_addr, 0);
        check_eq("rst_codec_wdata", codec_data_in, 0);

        // Gating, then fairness: all three write continuously from reset.
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 1'b1, 8'(8'h20 + i), 8'(8'h50 + i));
        wait_cycles(20);
        check_eq("gate_no_strobe", s_op_q.size(), 0);
        check_eq("gate_arb_idle",  arb_busy, 0);
        init_done = 1'b1;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h04);
        end
        wait_acks(6, 400, "rr_acks_seen");
        #1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_cycles(5);
        check_eq("rr_strobe_count", s_op_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            got_ack = (a_ack_q.size() > 0) ? a_ack_q.pop_front() : 8'h00;
            check_eq($sformatf("rr_grant_order%0d", i), got_ack, exp_q.pop_front());
            if (a_err_q.size() > 0) check_eq($sformatf("rr_err%0d", i), a_err_q.pop_front(), 0);
            if (s_addr_q.size() > 0) check_eq($sformatf("rr_addr%0d", i), s_addr_q.pop_front(), exp_addr[i]);
        end

        // Single write from requester 1; lane changes after grant are ignored.
        clear_logs();
        set_req(1, 1'b0, 1'b1, 8'h12, 8'hA5);
        wait_strobes(1, 50, "w_strobe_seen");
        #1 set_req(1, 1'b0, 1'b1, 8'h99, 8'h00);
        wait_acks(1, 100, "w_ack_seen");
        #1 set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_cycles(3);
        check_eq("w_strobe_count", s_op_q.size(), 1);
        check_eq("w_ack_count",    a_ack_q.size(), 1);
        if (s_op_q.size() > 0 && a_ack_q.size() > 0) begin
            check_eq("w_op",        s_op_q[0], 2'b10);
            check_eq("w_addr",      s_addr_q[0], 8'h12);
            check_eq("w_data",      s_data_q[0], 8'hA5);
            check_eq("w_ack_vec",   a_ack_q[0], 8'h02);
            check_eq("w_err",       a_err_q[0], 0);
            check_eq("w_rd_valid",  a_vld_q[0], 8'h00);
            check_eq("w_addr_hold", a_addr_q[0], 8'h12);
            check_eq("w_data_hold", a_wdata_q[0], 8'hA5);
            check_eq("w_latency",   a_cyc_q[0] - s_cyc_q[0], 12);
        end

        // Read from requester 0, request dropped right after grant.
        clear_logs();
        rd_value = 8'h3C;
        set_req(0, 1'b1, 1'b0, 8'h07, 8'h00);
        wait_strobes(1, 50, "r_strobe_seen");
        #1 set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_acks(1, 100, "r_ack_seen");
        wait_cycles(3);
        if (s_op_q.size() > 0 && a_ack_q.size() > 0) begin
            check_eq("r_op",       s_op_q[0], 2'b01);
            check_eq("r_addr",     s_addr_q[0], 8'h07);
            check_eq("r_ack_vec",  a_ack_q[0], 8'h01);
            check_eq("r_rd_valid", a_vld_q[0], 8'h01);
            check_eq("r_rd_data",  a_data_q[0], 8'h3C);
            check_eq("r_err",      a_err_q[0], 0);
        end

        // Requester 2 asserts read and write together: a write is issued.
        clear_logs();
        set_req(2, 1'b1, 1'b1, 8'h33, 8'h5A);
        wait_strobes(1, 50, "b_strobe_seen");
        wait_acks(1, 100, "b_ack_seen");
        #1 set_req(2, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_cycles(3);
        if (s_op_q.size() > 0 && a_ack_q.size() > 0) begin
            check_eq("b_op",       s_op_q[0], 2'b10);
            check_eq("b_data",     s_data_q[0], 8'h5A);
            check_eq("b_ack_vec",  a_ack_q[0], 8'h04);
            check_eq("b_rd_valid", a_vld_q[0], 8'h00);
        end

        // Reset while in WAIT_LO: transaction aborts with no ack.
        clear_logs();
        set_req(1, 1'b0, 1'b1, 8'h44, 8'h11);
        wait_strobes(1, 50, "x_strobe_seen");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("x_arb_busy",   arb_busy, 0);
        check_eq("x_rd_data",    req_data_out, 8'h00);
        check_eq("x_codec_addr", codec_reg_addr, 8'h00);
        check_eq("x_codec_wr",   codec_wr_en, 0);
        wait_cycles(20);
        check_eq("x_no_ack", a_ack_q.size(), 0);

`ifdef CODEC_ARB_TIMEOUT_EN
        // Busy stuck high on a read: ack with error and 8'hFF after the limit.
        ctl_enable = 1'b0;
        clear_logs();
        set_req(0, 1'b1, 1'b0, 8'h55, 8'h00);
        wait_strobes(1, 50, "t_strobe_seen");
        #1 controller_busy = 1'b1;
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_acks(1, 200, "t_ack_seen");
        #1 controller_busy = 1'b0;
        ctl_enable = 1'b1;
        wait_cycles(3);
        if (s_op_q.size() > 0 && a_ack_q.size() > 0) begin
            check_eq("t_err",      a_err_q[0], 1);
            check_eq("t_ack_vec",  a_ack_q[0], 8'h01);
            check_eq("t_rd_valid", a_vld_q[0], 8'h01);
            check_eq("t_rd_data",  a_data_q[0], 8'hFF);
            check_eq("t_latency",  a_cyc_q[0] - s_cyc_q[0], 51);
        end
        check_eq("t_err_after", req_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
